// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter.
//   state_t : FSM state encoding (IDLE / GRANT)
//   NCH     : number of requesting channels
//   CH_W    : width of a channel index
//   onehot  : channel index -> one-hot grant vector
package rr_sel_arbiter_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NCH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick4.sv
// Circular priority scan for four requesters.
// Ports:
//   req    [3:0] in  : request vector
//   last   [1:0] in  : index of the most recent owner
//   winner [1:0] out : first set request scanning last+1, last+2, last+3, last
//   any          out : at least one request is set
module rr_pick4
    import rr_sel_arbiter_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] winner,
    output logic            any
);

    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        any    = |req;
        // Offset 4 wraps back onto last itself, so it is checked last.
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = last + CH_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 mux.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : synchronous active-high reset
//   req    [3:0] in  : per-channel request (bit i = mux input i)
//   done         in  : owner finished; only looked at while granting
//   gnt    [3:0] out : registered one-hot grant, zero when idle
//   sel    [1:0] out : registered owner index, held through idle
//   busy         out : high while granting
//   timeout      out : one-cycle pulse when the hold limit forces release
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            done,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] sel,
    output logic            busy,
    output logic            timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CH_W-1:0] last_q, last_d;

    logic [CH_W-1:0] winner;
    logic            any;
    logic            limit_hit;
    logic            release_now;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        release_now = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d    = ST_GRANT;
                    gnt_d      = onehot(winner);
                    sel_d      = winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                release_now = done || !req[sel_q] || limit_hit;
                if (release_now) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    last_d    = sel_q;
                    // done and a dropped request both take precedence over the limit.
                    timeout_d = limit_hit && !done && req[sel_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= CH_W'(NCH - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
